// File: rtl/mov_seq_pkg.sv
// Shared constants for the mov-lane sequencer: FSM encoding and requester indices.
package mov_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; last_i is the index of the previous winner.
module rr_arb2
  import mov_seq_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] win_c_o
);

  // On a tie the requester that did not win last time gets the lane.
  always_comb begin
    win_c_o = 2'b00;
    if (req_i[REQ0] && (!req_i[REQ1] || last_i)) begin
      win_c_o[REQ0] = 1'b1;
    end else if (req_i[REQ1]) begin
      win_c_o[REQ1] = 1'b1;
    end
  end

endmodule

// File: rtl/mov_seq_ctrl.sv
// Shares one 1-bit mov lane between two requesters: serialises a word LSB-first
// through the lane and reassembles the returned bits into dst_word.
module mov_seq_ctrl
  import mov_seq_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] src_word0,
  input  logic [WIDTH-1:0] src_word1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             mov_in,
  input  logic             mov_out,
  output logic [WIDTH-1:0] dst_word,
  output logic             done
);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] src_shreg_q, src_shreg_d;
  logic [WIDTH-1:0] dst_shreg_q, dst_shreg_d;
  logic [WIDTH-1:0] dst_word_q, dst_word_d;
  logic [1:0]       win_c;

  rr_arb2 u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .win_c_o (win_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      src_shreg_q <= '0;
      dst_shreg_q <= '0;
      dst_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      src_shreg_q <= src_shreg_d;
      dst_shreg_q <= dst_shreg_d;
      dst_word_q  <= dst_word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    last_d      = last_q;
    cnt_d       = cnt_q;
    src_shreg_d = src_shreg_q;
    dst_shreg_d = dst_shreg_q;
    dst_word_d  = dst_word_q;
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_LOAD;
          grant_d = win_c;
          busy_d  = 1'b1;
        end
      end
      // Source word is captured here, so later src_word changes cannot disturb the transfer.
      S_LOAD: begin
        src_shreg_d = grant_q[REQ1] ? src_word1 : src_word0;
        cnt_d       = '0;
        last_d      = grant_q[REQ1];
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        dst_shreg_d = {mov_out, dst_shreg_q[WIDTH-1:1]};
        src_shreg_d = src_shreg_q >> 1;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          dst_word_d = dst_shreg_d;
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dst_word = dst_word_q;
  assign mov_in   = (state_q == S_SHIFT) && src_shreg_q[0];

endmodule

// File: tb/tb_mov_seq_ctrl.sv
// Directed bench for mov_seq_ctrl: WIDTH=8 instance plus a WIDTH=2 instance,
// each with its mov lane looped straight back.
module tb_mov_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req;
  logic [7:0] src0, src1;
  logic [1:0] grant;
  logic       busy, mov_in, mov_out, done;
  logic [7:0] dst;

  logic [1:0] req2;
  logic [1:0] s2_0, s2_1;
  logic [1:0] grant2;
  logic       busy2, mov_in2, mov_out2, done2;
  logic [1:0] dst2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mov_out  = mov_in;
  assign mov_out2 = mov_in2;

  mov_seq_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_word0(src0), .src_word1(src1),
    .grant(grant), .busy(busy), .mov_in(mov_in), .mov_out(mov_out),
    .dst_word(dst), .done(done)
  );

  mov_seq_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .src_word0(s2_0), .src_word1(s2_1),
    .grant(grant2), .busy(busy2), .mov_in(mov_in2), .mov_out(mov_out2),
    .dst_word(dst2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_mov_in", 32'(mov_in), 32'h0);
    check("rst_dst", 32'(dst), 32'h0);
    check("rst_dst2", 32'(dst2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called in an IDLE cycle with req already applied; returns in the following IDLE cycle.
  task automatic xfer(input string tag, input logic [1:0] eg, input logic [7:0] w);
    tick();
    check({tag, "_load_grant"}, 32'(grant), 32'(eg));
    check({tag, "_load_busy"}, 32'(busy), 32'h1);
    check({tag, "_load_mov_in"}, 32'(mov_in), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, "_shift_mov_in"}, 32'(mov_in), 32'(w[i]));
      check({tag, "_shift_busy"}, 32'(busy), 32'h1);
      check({tag, "_shift_done"}, 32'(done), 32'h0);
      check({tag, "_shift_grant"}, 32'(grant), 32'(eg));
    end
    tick();
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_dst"}, 32'(dst), 32'(w));
    check({tag, "_done_busy"}, 32'(busy), 32'h0);
    check({tag, "_done_grant"}, 32'(grant), 32'(eg));
    check({tag, "_done_mov_in"}, 32'(mov_in), 32'h0);
    tick();
    check({tag, "_idle_done"}, 32'(done), 32'h0);
    check({tag, "_idle_grant"}, 32'(grant), 32'h0);
    check({tag, "_idle_dst_hold"}, 32'(dst), 32'(w));
  endtask

  initial begin
    logic [7:0] w0f;
    req = 2'b00; src0 = 8'h00; src1 = 8'h00;
    req2 = 2'b00; s2_0 = 2'b00; s2_1 = 2'b00;
    #1;
    do_reset();

    // Single requester, A5 through the loop-back lane.
    req = 2'b01; src0 = 8'hA5;
    xfer("single", 2'b01, 8'hA5);
    req = 2'b00;
    tick();
    check("single_stay_idle", 32'(grant), 32'h0);

    // Tie after reset, then fairness while both keep requesting.
    do_reset();
    req = 2'b11; src0 = 8'h3C; src1 = 8'hC3;
    xfer("tie0", 2'b01, 8'h3C);
    xfer("tie1", 2'b10, 8'hC3);
    xfer("fair2", 2'b01, 8'h3C);
    xfer("fair3", 2'b10, 8'hC3);

    // Reset pulled during the fourth SHIFT cycle.
    req = 2'b10; src1 = 8'hFF;
    tick();
    check("mid_load_grant", 32'(grant), 32'h2);
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy_before", 32'(busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_dst", 32'(dst), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_mov_in", 32'(mov_in), 32'h0);
    #1 rst_n = 1'b1;
    xfer("rst_retry", 2'b10, 8'hFF);

    // Source and request changes after capture do not disturb the transfer.
    w0f = 8'h0F;
    req = 2'b01; src0 = 8'h0F;
    tick();
    check("stab_load_grant", 32'(grant), 32'h1);
    tick();
    check("stab_mov_in0", 32'(mov_in), 32'(w0f[0]));
    src0 = 8'hF0; req = 2'b00;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("stab_mov_in", 32'(mov_in), 32'(w0f[i]));
    end
    tick();
    check("stab_done", 32'(done), 32'h1);
    check("stab_dst", 32'(dst), 32'h0F);
    tick();
    check("stab_idle_grant", 32'(grant), 32'h0);
    tick();
    check("stab_no_restart", 32'(grant), 32'h0);
    check("stab_no_restart_busy", 32'(busy), 32'h0);

    // Edge data values.
    req = 2'b01; src0 = 8'h00;
    xfer("zero", 2'b01, 8'h00);
    src0 = 8'hFF;
    xfer("ones", 2'b01, 8'hFF);
    req = 2'b00;

    // WIDTH=2 instance: done at cycle 4.
    req2 = 2'b01; s2_0 = 2'b10;
    tick();
    check("w2_grant", 32'(grant2), 32'h1);
    check("w2_busy", 32'(busy2), 32'h1);
    tick();
    check("w2_mov_in0", 32'(mov_in2), 32'h0);
    check("w2_done_early", 32'(done2), 32'h0);
    tick();
    check("w2_mov_in1", 32'(mov_in2), 32'h1);
    tick();
    check("w2_done", 32'(done2), 32'h1);
    check("w2_dst", 32'(dst2), 32'h2);
    req2 = 2'b00;
    tick();
    check("w2_done_pulse", 32'(done2), 32'h0);
    check("w2_idle_grant", 32'(grant2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
